keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Input-side counterpart of the 4-digit seven-segment display driver.
- Scans a 4x4 active-low matrix keypad by rotating a one-hot-low column drive, much as the display rotates its anodes.
- Debounces key presses and decodes each accepted press to a 4-bit hex code.
- Shifts each code into a 16-bit value, with a set pulse that feeds the display driver's value/set inputs directly.

Parameters:
- SCAN_DIV, 1000, clk cycles each column is driven; must be >= 4.
- DEBOUNCE, 4, consecutive identical scan frames needed to accept a press or a release; must be >= 1.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- row  in  4  keypad row lines, active-low, externally pulled up, asynchronous
- col  out  4  column drive, one-hot active-low
- key_code  out  4  code of the last accepted key
- key_valid  out  1  one-cycle pulse on press acceptance
- value  out  16  shift register of the last four accepted codes; newest in [3:0]
- set  out  1  one-cycle pulse, coincident with key_valid, when value updates

Behaviour:
- Reset values: col=4'b1110, key_code=0, key_valid=0, value=0, set=0, FSM=IDLE; all counters and the frame accumulator cleared.
- Reset mid-scan or mid-debounce discards all progress.
- row passes through a 2-flop synchronizer before use (2-cycle latency).
- Divider div_cnt counts 0..SCAN_DIV-1.
- On the cycle div_cnt==SCAN_DIV-1:
  - sample synchronized rows for the active column c (index of the 0 bit in col);
  - rotate col left by one (1110 -> 1101 -> 1011 -> 0111 -> 1110);
  - reset div_cnt to 0.
- Column index wraps 3 -> 0. One frame = 4 columns = 4*SCAN_DIV cycles.
- Key code for row r low while column c is driven: code = 4*r + c, r and c in 0..3.
- Frame result, evaluated on the sample of column 3:
  - NONE: zero low rows across the frame.
  - SINGLE(code): exactly one row low in exactly one column.
  - MULTI: any other pattern (ghosting or two keys).
- FSM, updated once per frame result only; frame_cnt counts qualifying frames:
  - IDLE:
    - SINGLE(k): latch cand=k, frame_cnt=1, go to PRESS_DB. If DEBOUNCE==1, accept immediately instead.
    - NONE or MULTI: stay.
  - PRESS_DB:
    - SINGLE(cand): frame_cnt++. On reaching DEBOUNCE, accept and go to HELD.
    - SINGLE(other k): cand=k, frame_cnt=1, stay.
    - NONE or MULTI: go to IDLE.
  - HELD:
    - NONE: frame_cnt=1, go to REL_DB; if DEBOUNCE==1, go to IDLE.
    - SINGLE or MULTI: stay. No auto-repeat; a second key while held is ignored.
  - REL_DB:
    - NONE: frame_cnt++. On reaching DEBOUNCE, go to IDLE.
    - SINGLE or MULTI: go to HELD.
- Accept action, on the cycle after the deciding column-3 sample:
  - key_code <= cand;
  - value <= {value[11:0], cand};
  - key_valid = set = 1 for exactly one cycle.
- The scan never stalls; column rotation continues in every state.
- Counter widths: div_cnt $clog2(SCAN_DIV); frame_cnt $clog2(DEBOUNCE+1). Neither counter overflows.

Decomposition:
- Package keypad_pkg holds:
  - FSM state typedef (IDLE, PRESS_DB, HELD, REL_DB);
  - frame-result typedef (NONE, SINGLE, MULTI);
  - constants KP_ROWS=4, KP_COLS=4, CODE_W=4.
- One sub-module, sync2: a parameterised-width 2-flop synchronizer, instantiated for row.
- Scan divider, frame accumulator and FSM stay in keypad_scanner.

Test Plan (SCAN_DIV=4, DEBOUNCE=2, frame=16 cycles):
- Reset, then idle with row=4'hF:
  - col cycles 1110, 1101, 1011, 0111 every 4 cycles;
  - value=0; set is never asserted.
- Hold row[1] low only while col=1011 (key r1c2) for 3 frames:
  - exactly one key_valid/set pulse, key_code=4'h6, value=16'h0006, at the end of frame 2;
  - no pulse in frame 3.
- Release for 2 frames, then press r3c3, release, press r0c1:
  - value=16'h0006 -> 16'h006F -> 16'h06F1;
  - key_codes F then 1.
- Bounce (r2c0 present one frame, absent one frame, repeatedly):
  - no pulse;
  - FSM oscillates between IDLE and PRESS_DB.
- Two keys (r0c0 and r1c1) held 4 frames:
  - MULTI every frame; no pulse.
  - While r2c3 is held in HELD, adding r0c0: no second pulse.
- Assert rst mid-PRESS_DB:
  - all outputs return to reset values; col=1110.
  - The next press needs a full 2 frames again.
- Five presses:
  - value keeps only the last four codes; the oldest nibble is dropped.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
// Latency: n/a (package only).
// Backpressure: n/a.
package keypad_pkg;

   localparam int KP_ROWS = 4;
   localparam int KP_COLS = 4;
   localparam int CODE_W  = 4;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PRESS_DB = 2'd1,
      HELD     = 2'd2,
      REL_DB   = 2'd3
   } kp_state_t;

   typedef enum logic [1:0] {
      NONE   = 2'd0,
      SINGLE = 2'd1,
      MULTI  = 2'd2
   } frame_res_t;

   // Index of the low bit of a one-hot-low column drive.
   function automatic logic [1:0] col_index(input logic [KP_COLS-1:0] c);
      logic [1:0] idx;
      idx = 2'd0;
      case (c)
         4'b1110: idx = 2'd0;
         4'b1101: idx = 2'd1;
         4'b1011: idx = 2'd2;
         4'b0111: idx = 2'd3;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

   // Number of asserted bits in a 4-bit vector.
   function automatic logic [2:0] popcount4(input logic [3:0] v);
      return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
   endfunction

   // Index of the highest asserted bit; only meaningful when exactly one bit is set.
   function automatic logic [1:0] row_index(input logic [3:0] v);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (v[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/keypad_scanner_sync.sv
// Generic W-bit two-flop synchronizer for asynchronous level inputs.
// Latency: 2 clk cycles.
// Backpressure: none; samples every cycle.
module sync2 #(
   parameter int             W       = 1,
   parameter logic [W-1:0]   RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta;

   // Two back-to-back flops; reset value is the idle level of the line.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// Scans a 4x4 active-low keypad, debounces presses and shifts hex codes into a 16-bit value.
// Latency: accepted press reported one cycle after the deciding column-3 sample.
// Backpressure: none; scan runs continuously and key_valid/set are single-cycle pulses.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV = 1000,
   parameter int DEBOUNCE = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [KP_ROWS-1:0]  row,
   output logic [KP_COLS-1:0]  col,
   output logic [CODE_W-1:0]   key_code,
   output logic                key_valid,
   output logic [15:0]         value,
   output logic                set
);

   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam int FC_W  = $clog2(DEBOUNCE + 1);

   logic [KP_ROWS-1:0] row_sync;
   logic [DIV_W-1:0]   div_cnt;
   logic               col_tick;
   logic               frame_done;
   logic [1:0]         cidx;

   // Accumulator: number of low (row, column) hits this frame, saturating at 2.
   logic [1:0]         acc_hits;
   logic [CODE_W-1:0]  acc_code;
   logic [1:0]         hits_now;
   logic [CODE_W-1:0]  code_now;
   logic [KP_ROWS-1:0] rows_low;
   logic [2:0]         low_cnt;
   frame_res_t         frame_res;

   kp_state_t          state_q, state_d;
   logic [CODE_W-1:0]  cand_q, cand_d;
   logic [FC_W-1:0]    fcnt_q, fcnt_d;
   logic               accept;
   logic [CODE_W-1:0]  accept_code;

   sync2 #(.W(KP_ROWS), .RST_VAL({KP_ROWS{1'b1}})) u_row_sync (
      .clk (clk),
      .rst (rst),
      .d   (row),
      .q   (row_sync)
   );

   assign col_tick   = (div_cnt == DIV_W'(SCAN_DIV - 1));
   assign cidx       = col_index(col);
   assign frame_done = col_tick && (cidx == 2'd3);

   // Column dwell divider.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt <= '0;
      end else if (col_tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

   // Rotate the low column left once per dwell period.
   always_ff @(posedge clk) begin
      if (rst) begin
         col <= 4'b1110;
      end else if (col_tick) begin
         col <= {col[KP_COLS-2:0], col[KP_COLS-1]};
      end
   end

   // Fold the current column's sample into the running frame tally.
   always_comb begin
      rows_low = ~row_sync;
      low_cnt  = popcount4(rows_low);
      hits_now = acc_hits;
      code_now = acc_code;
      if (low_cnt == 3'd1) begin
         if (acc_hits == 2'd0) begin
            hits_now = 2'd1;
            code_now = {row_index(rows_low), cidx};
         end else begin
            hits_now = 2'd2;
         end
      end else if (low_cnt != 3'd0) begin
         hits_now = 2'd2;
      end
      if (hits_now == 2'd0) begin
         frame_res = NONE;
      end else if (hits_now == 2'd1) begin
         frame_res = SINGLE;
      end else begin
         frame_res = MULTI;
      end
   end

   // Frame accumulator: updated on each column sample, cleared at frame end.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_hits <= '0;
         acc_code <= '0;
      end else if (frame_done) begin
         acc_hits <= '0;
         acc_code <= '0;
      end else if (col_tick) begin
         acc_hits <= hits_now;
         acc_code <= code_now;
      end
   end

   // Debounce FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cand_q  <= '0;
         fcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         cand_q  <= cand_d;
         fcnt_q  <= fcnt_d;
      end
   end

   // Debounce FSM next-state: advances only on a completed frame.
   always_comb begin
      state_d     = state_q;
      cand_d      = cand_q;
      fcnt_d      = fcnt_q;
      accept      = 1'b0;
      accept_code = cand_q;
      if (frame_done) begin
         case (state_q)
            IDLE: begin
               if (frame_res == SINGLE) begin
                  cand_d = code_now;
                  if (DEBOUNCE == 1) begin
                     accept      = 1'b1;
                     accept_code = code_now;
                     state_d     = HELD;
                  end else begin
                     fcnt_d  = FC_W'(1);
                     state_d = PRESS_DB;
                  end
               end
            end
            PRESS_DB: begin
               if (frame_res == SINGLE) begin
                  if (code_now == cand_q) begin
                     if (fcnt_q + FC_W'(1) == FC_W'(DEBOUNCE)) begin
                        accept  = 1'b1;
                        state_d = HELD;
                     end else begin
                        fcnt_d = fcnt_q + FC_W'(1);
                     end
                  end else begin
                     cand_d = code_now;
                     fcnt_d = FC_W'(1);
                  end
               end else begin
                  state_d = IDLE;
               end
            end
            HELD: begin
               if (frame_res == NONE) begin
                  if (DEBOUNCE == 1) begin
                     state_d = IDLE;
                  end else begin
                     fcnt_d  = FC_W'(1);
                     state_d = REL_DB;
                  end
               end
            end
            REL_DB: begin
               if (frame_res == NONE) begin
                  if (fcnt_q + FC_W'(1) == FC_W'(DEBOUNCE)) begin
                     state_d = IDLE;
                  end else begin
                     fcnt_d = fcnt_q + FC_W'(1);
                  end
               end else begin
                  state_d = HELD;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Register the accepted code and shift it into the display value.
   always_ff @(posedge clk) begin
      if (rst) begin
         key_code  <= '0;
         key_valid <= 1'b0;
         value     <= '0;
         set       <= 1'b0;
      end else begin
         key_valid <= accept;
         set       <= accept;
         if (accept) begin
            key_code <= accept_code;
            value    <= {value[11:0], accept_code};
         end
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with a behavioural keypad matrix.
// Latency: n/a.
// Backpressure: n/a.
module tb_keypad_scanner;
   import keypad_pkg::*;

   localparam int SD    = 4;
   localparam int DB    = 2;
   localparam int FRAME = 4 * SD;

   logic        clk;
   logic        rst;
   logic [3:0]  row;
   logic [3:0]  col;
   logic [3:0]  key_code;
   logic        key_valid;
   logic [15:0] value;
   logic        set;

   logic [15:0] pressed;
   logic [15:0] exp_value;
   logic [19:0] exp_q[$];
   int          checks;
   int          failures;
   int          pulses;
   int          exp_pulses;

   keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
      .clk       (clk),
      .rst       (rst),
      .row       (row),
      .col       (col),
      .key_code  (key_code),
      .key_valid (key_valid),
      .value     (value),
      .set       (set)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Keypad matrix: a pressed key pulls its row low while its column is driven.
   always_comb begin
      row = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (pressed[4*r+c] && !col[c]) row[r] = 1'b0;
         end
      end
   end

   task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every press pulse is matched against the oldest expected entry.
   always @(negedge clk) begin
      if (!rst) begin
         check_eq("set_eq_key_valid", 32'(set), 32'(key_valid));
         if (key_valid) begin
            pulses++;
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_pulse: got key_code=0x%0h value=0x%0h, expected no pulse", key_code, value);
            end else begin
               logic [19:0] e;
               e = exp_q.pop_front();
               if (key_code !== e[19:16] || value !== e[15:0]) begin
                  failures++;
                  $display("FAIL pulse_data: got key_code=0x%0h value=0x%0h, expected key_code=0x%0h value=0x%0h",
                           key_code, value, e[19:16], e[15:0]);
               end
            end
         end
      end
   end

   function automatic logic [15:0] key(input int r, input int c);
      logic [15:0] one;
      one = 16'h0001;
      return one << (4*r + c);
   endfunction

   task automatic run(input logic [15:0] m, input int n);
      pressed = m;
      repeat (n * FRAME) @(posedge clk);
      #1;
   endtask

   task automatic expect_press(input logic [3:0] code);
      exp_value = {exp_value[11:0], code};
      exp_q.push_back({code, exp_value});
      exp_pulses++;
   endtask

   task automatic press(input int r, input int c);
      expect_press(4'(4*r + c));
      run(key(r, c), DB);
      run(16'h0, DB);
      check_eq("pulse_count", 32'(pulses), 32'(exp_pulses));
   endtask

   task automatic check_reset_outputs();
      check_eq("rst_col", 32'(col), 32'h0000000E);
      check_eq("rst_key_code", 32'(key_code), 32'h0);
      check_eq("rst_value", 32'(value), 32'h0);
      check_eq("rst_key_valid", 32'(key_valid), 32'h0);
      check_eq("rst_set", 32'(set), 32'h0);
      check_eq("rst_state", 32'(dut.state_q), 32'(IDLE));
   endtask

   initial begin
      logic [3:0] one4;
      logic [3:0] exp_col;
      checks     = 0;
      failures   = 0;
      pulses     = 0;
      exp_pulses = 0;
      exp_value  = 16'h0;
      pressed    = 16'h0;
      one4       = 4'b0001;
      rst        = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs();
      rst = 1'b0;

      // Idle scan: two full frames of column rotation.
      for (int k = 0; k < 2 * FRAME; k++) begin
         @(negedge clk);
         exp_col = ~(one4 << ((k / SD) % 4));
         check_eq("idle_col", 32'(col), 32'(exp_col));
      end
      @(posedge clk);
      #1;
      check_eq("idle_value", 32'(value), 32'h0);

      // r1c2 held three frames: one pulse, code 6.
      expect_press(4'h6);
      run(key(1, 2), 1);
      check_eq("r1c2_one_frame_no_pulse", 32'(pulses), 32'd0);
      run(key(1, 2), 2);
      check_eq("r1c2_held_state", 32'(dut.state_q), 32'(HELD));
      run(16'h0, 2);
      check_eq("r1c2_pulses", 32'(pulses), 32'd1);
      check_eq("r1c2_value", 32'(value), 32'h0006);

      press(3, 3);
      check_eq("r3c3_value", 32'(value), 32'h006F);
      press(0, 1);
      check_eq("r0c1_value", 32'(value), 32'h06F1);
      check_eq("r0c1_code", 32'(key_code), 32'h1);

      // Bouncing r2c0: alternate present/absent frames.
      for (int i = 0; i < 4; i++) begin
         run(key(2, 0), 1);
         check_eq("bounce_press_db", 32'(dut.state_q), 32'(PRESS_DB));
         run(16'h0, 1);
         check_eq("bounce_idle", 32'(dut.state_q), 32'(IDLE));
      end
      check_eq("bounce_pulses", 32'(pulses), 32'(exp_pulses));

      // Two keys together never qualify.
      run(key(0, 0) | key(1, 1), 4);
      check_eq("multi_state", 32'(dut.state_q), 32'(IDLE));
      run(16'h0, 2);
      check_eq("multi_pulses", 32'(pulses), 32'(exp_pulses));

      // Second key while one is held is ignored.
      expect_press(4'hB);
      run(key(2, 3), 2);
      run(key(2, 3) | key(0, 0), 2);
      check_eq("held_second_state", 32'(dut.state_q), 32'(HELD));
      run(16'h0, 2);
      check_eq("held_second_pulses", 32'(pulses), 32'(exp_pulses));
      check_eq("held_second_value", 32'(value), 32'h6F1B);

      // Reset in the middle of press debounce.
      run(key(1, 0), 1);
      check_eq("pre_rst_state", 32'(dut.state_q), 32'(PRESS_DB));
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_reset_outputs();
      exp_value = 16'h0;
      rst = 1'b0;
      run(key(1, 0), 1);
      check_eq("post_rst_one_frame", 32'(pulses), 32'(exp_pulses));
      expect_press(4'h4);
      run(key(1, 0), 1);
      run(16'h0, 2);
      check_eq("post_rst_pulses", 32'(pulses), 32'(exp_pulses));
      check_eq("post_rst_value", 32'(value), 32'h0004);

      // Five presses: only the last four codes remain.
      press(0, 1);
      press(0, 2);
      press(0, 3);
      press(2, 2);
      press(1, 3);
      check_eq("five_value", 32'(value), 32'h23A7);
      check_eq("five_code", 32'(key_code), 32'h7);

      check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
